// File: rtl/regfile_mp.sv
// Multi-read-port integer register file: registered reads with write-first bypass,
// hardwired-zero x0, a sequencer that zeroes the array after reset or clear, and a debug tap.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NREAD   = 2,
  parameter int DBG_REG = 10,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic [XLEN-1:0]       dbg_data
);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  state_t          state_reg;
  state_t          state_next;
  logic [AW-1:0]   clr_cnt_reg;
  logic [AW-1:0]   clr_cnt_next;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            wr_live;

  logic [XLEN-1:0] mem [NREGS];

  // An architectural write only exists in READY and never targets x0.
  assign wr_live = (state_reg == S_READY) && we && (wr_addr != '0);
  assign ready   = (state_reg == S_READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_CLEAR;
      clr_cnt_reg <= FIRST_IDX;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    case (state_reg)
      S_CLEAR: begin
        // The sequencer owns the write port; x0 is never stored, so it starts at 1.
        mem_we       = 1'b1;
        mem_waddr    = clr_cnt_reg;
        mem_wdata    = '0;
        clr_cnt_next = clr_cnt_reg + FIRST_IDX;
        if (clr_cnt_reg == LAST_IDX) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        mem_we = wr_live;
        if (clear) begin
          state_next   = S_CLEAR;
          clr_cnt_next = FIRST_IDX;
        end
      end
      default: begin
        state_next   = S_CLEAR;
        clr_cnt_next = FIRST_IDX;
      end
    endcase
  end

  // Storage has no reset so it maps onto plain memory; zeroing is the sequencer's job.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] q_reg;

    assign addr = rd_addr[gi*AW +: AW];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_reg <= '0;
      end else if ((state_reg != S_READY) || (addr == '0)) begin
        q_reg <= '0;
      end else if (wr_live && (wr_addr == addr)) begin
        q_reg <= wr_data;
      end else begin
        q_reg <= mem[addr];
      end
    end

    assign rd_data[gi*XLEN +: XLEN] = q_reg;
  end

  if (DBG_REG == 0) begin : g_dbg_zero
    assign dbg_data = '0;
  end else begin : g_dbg
    localparam logic [AW-1:0] DBG_IDX = AW'(DBG_REG);
    logic [XLEN-1:0] dbg_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dbg_reg <= '0;
      end else if (state_reg != S_READY) begin
        dbg_reg <= '0;
      end else if (wr_live && (wr_addr == DBG_IDX)) begin
        dbg_reg <= wr_data;
      end else begin
        dbg_reg <= mem[DBG_IDX];
      end
    end

    assign dbg_data = dbg_reg;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: runs the same suite on a 32x32/2-port and a 16x64/3-port instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clear;
  logic        we;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  ra [3];

  logic        ready_a;
  logic [63:0] rd_a;
  logic [31:0] dbg_a;
  logic        ready_b;
  logic [191:0] rd_b;
  logic [63:0] dbg_b;

  int errors = 0;
  int checks = 0;
  int cfg    = 0;

  regfile_mp u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .ready    (ready_a),
    .rd_addr  ({ra[1], ra[0]}),
    .rd_data  (rd_a),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data[31:0]),
    .dbg_data (dbg_a)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .ready    (ready_b),
    .rd_addr  ({ra[2][3:0], ra[1][3:0], ra[0][3:0]}),
    .rd_data  (rd_b),
    .we       (we),
    .wr_addr  (wr_addr[3:0]),
    .wr_data  (wr_data),
    .dbg_data (dbg_b)
  );

  function automatic int nregs();
    return (cfg != 0) ? 16 : 32;
  endfunction

  function automatic int nread();
    return (cfg != 0) ? 3 : 2;
  endfunction

  function automatic logic [63:0] mask();
    return (cfg != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] obs_rd(int i);
    if (cfg != 0) return rd_b[i*64 +: 64];
    return {32'h0, rd_a[i*32 +: 32]};
  endfunction

  function automatic logic [63:0] obs_dbg();
    return (cfg != 0) ? dbg_b : {32'h0, dbg_a};
  endfunction

  function automatic logic obs_ready();
    return (cfg != 0) ? ready_b : ready_a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we      = 1'b0;
    clear   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 3; i++) ra[i] = '0;
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs_ready() !== 1'b0 || obs_rd(0) !== 64'h0 || obs_dbg() !== 64'h0) begin
      errors++;
      $display("FAIL cfg%0d reset_outputs: ready=%b rd0=%h dbg=%h, need 0/0/0", cfg, obs_ready(), obs_rd(0), obs_dbg());
    end else $display("cfg%0d reset_outputs ok", cfg);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    while (obs_ready() !== 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != nregs() - 1) begin
      errors++;
      $display("FAIL cfg%0d reset_clear_len: %0d cycles, need %0d", cfg, cnt, nregs() - 1);
    end else $display("cfg%0d reset_clear_len %0d ok", cfg, cnt);
    ra[0] = 5'd1;
    ra[1] = 5'd2;
    ra[2] = 5'(nregs() - 1);
    tick();
    for (int i = 0; i < nread(); i++) begin
      checks++;
      if (obs_rd(i) !== 64'h0) begin
        errors++;
        $display("FAIL cfg%0d reset_read port%0d: got %h, need 0", cfg, i, obs_rd(i));
      end else $display("cfg%0d reset_read port%0d ok", cfg, i);
    end
    checks++;
    if (obs_dbg() !== 64'h0) begin
      errors++;
      $display("FAIL cfg%0d reset_dbg: got %h, need 0", cfg, obs_dbg());
    end else $display("cfg%0d reset_dbg ok", cfg);
  endtask

  task automatic test_write_read();
    logic [63:0] exp;
    idle();
    exp     = 64'hCAFE_F00D_DEAD_BEEF & mask();
    we      = 1'b1;
    wr_addr = 5'd5;
    wr_data = 64'hCAFE_F00D_DEAD_BEEF;
    tick();
    we = 1'b0;
    for (int i = 0; i < 3; i++) ra[i] = 5'd5;
    tick();
    for (int i = 0; i < nread(); i++) begin
      checks++;
      if (obs_rd(i) !== exp) begin
        errors++;
        $display("FAIL cfg%0d write_read port%0d: got %h, need %h", cfg, i, obs_rd(i), exp);
      end else $display("cfg%0d write_read x5 port%0d ok", cfg, i);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] exp;
    idle();
    we      = 1'b1;
    wr_addr = 5'd7;
    wr_data = 64'h1111;
    tick();
    exp     = 64'h0000_5678_0000_1234 & mask();
    wr_data = 64'h0000_5678_0000_1234;
    ra[1]   = 5'd7;
    tick();
    we = 1'b0;
    checks++;
    if (obs_rd(1) !== exp) begin
      errors++;
      $display("FAIL cfg%0d bypass: got %h, need %h", cfg, obs_rd(1), exp);
    end else $display("cfg%0d bypass x7 ok", cfg);
    checks++;
    if (obs_rd(0) !== 64'h0) begin
      errors++;
      $display("FAIL cfg%0d bypass_other_port: got %h, need 0", cfg, obs_rd(0));
    end else $display("cfg%0d bypass_other_port ok", cfg);
    tick();
    checks++;
    if (obs_rd(1) !== exp) begin
      errors++;
      $display("FAIL cfg%0d bypass_stored: got %h, need %h", cfg, obs_rd(1), exp);
    end else $display("cfg%0d bypass_stored ok", cfg);
  endtask

  task automatic test_back_to_back();
    idle();
    we      = 1'b1;
    wr_addr = 5'd8;
    wr_data = 64'hA000_0000_0000_0001;
    tick();
    wr_addr = 5'd9;
    wr_data = 64'hB000_0000_0000_0002;
    ra[0]   = 5'd8;
    ra[1]   = 5'd9;
    tick();
    we = 1'b0;
    checks++;
    if (obs_rd(0) !== (64'hA000_0000_0000_0001 & mask())) begin
      errors++;
      $display("FAIL cfg%0d b2b_prev: got %h, need %h", cfg, obs_rd(0), 64'hA000_0000_0000_0001 & mask());
    end else $display("cfg%0d b2b_prev ok", cfg);
    checks++;
    if (obs_rd(1) !== (64'hB000_0000_0000_0002 & mask())) begin
      errors++;
      $display("FAIL cfg%0d b2b_bypass: got %h, need %h", cfg, obs_rd(1), 64'hB000_0000_0000_0002 & mask());
    end else $display("cfg%0d b2b_bypass ok", cfg);
  endtask

  task automatic test_x0();
    idle();
    we      = 1'b1;
    wr_addr = 5'd0;
    wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    we = 1'b0;
    for (int i = 0; i < nread(); i++) begin
      checks++;
      if (obs_rd(i) !== 64'h0) begin
        errors++;
        $display("FAIL cfg%0d x0_bypass port%0d: got %h, need 0", cfg, i, obs_rd(i));
      end else $display("cfg%0d x0_bypass port%0d ok", cfg, i);
    end
    tick();
    for (int i = 0; i < nread(); i++) begin
      checks++;
      if (obs_rd(i) !== 64'h0) begin
        errors++;
        $display("FAIL cfg%0d x0_read port%0d: got %h, need 0", cfg, i, obs_rd(i));
      end else $display("cfg%0d x0_read port%0d ok", cfg, i);
    end
  endtask

  task automatic test_dbg();
    idle();
    we      = 1'b1;
    wr_addr = 5'd10;
    wr_data = 64'h55;
    tick();
    checks++;
    if (obs_dbg() !== 64'h55) begin
      errors++;
      $display("FAIL cfg%0d dbg_bypass: got %h, need 55", cfg, obs_dbg());
    end else $display("cfg%0d dbg_bypass ok", cfg);
    wr_addr = 5'd11;
    wr_data = 64'h66;
    tick();
    we = 1'b0;
    checks++;
    if (obs_dbg() !== 64'h55) begin
      errors++;
      $display("FAIL cfg%0d dbg_other_write: got %h, need 55", cfg, obs_dbg());
    end else $display("cfg%0d dbg_other_write ok", cfg);
  endtask

  task automatic test_async_reset();
    int cnt;
    idle();
    ra[0] = 5'd5;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_rd(0) !== 64'h0 || obs_dbg() !== 64'h0 || obs_ready() !== 1'b0) begin
      errors++;
      $display("FAIL cfg%0d async_reset: rd0=%h dbg=%h ready=%b, need 0/0/0", cfg, obs_rd(0), obs_dbg(), obs_ready());
    end else $display("cfg%0d async_reset ok", cfg);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    while (obs_ready() !== 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != nregs() - 1) begin
      errors++;
      $display("FAIL cfg%0d async_reset_clear_len: %0d cycles, need %0d", cfg, cnt, nregs() - 1);
    end else $display("cfg%0d async_reset_clear_len ok", cfg);
  endtask

  task automatic test_clear();
    int cnt;
    idle();
    we      = 1'b1;
    wr_addr = 5'd3;
    wr_data = 64'hA5;
    tick();
    we    = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt   = 0;
    while (obs_ready() !== 1'b1 && cnt < 100) begin
      cnt++;
      clear   = (cnt == 2);
      we      = (cnt == 5);
      wr_addr = 5'd3;
      wr_data = 64'h77;
      ra[0]   = 5'd3;
      tick();
      if (cnt == 5) begin
        checks++;
        if (obs_rd(0) !== 64'h0) begin
          errors++;
          $display("FAIL cfg%0d clear_read_zero: got %h, need 0", cfg, obs_rd(0));
        end else $display("cfg%0d clear_read_zero ok", cfg);
      end
    end
    we    = 1'b0;
    clear = 1'b0;
    checks++;
    if (cnt != nregs() - 1) begin
      errors++;
      $display("FAIL cfg%0d clear_len: %0d cycles, need %0d", cfg, cnt, nregs() - 1);
    end else $display("cfg%0d clear_len %0d ok", cfg, cnt);
    tick();
    checks++;
    if (obs_rd(0) !== 64'h0) begin
      errors++;
      $display("FAIL cfg%0d clear_x3: got %h, need 0", cfg, obs_rd(0));
    end else $display("cfg%0d clear_x3 ok", cfg);
    checks++;
    if (obs_dbg() !== 64'h0) begin
      errors++;
      $display("FAIL cfg%0d clear_dbg: got %h, need 0", cfg, obs_dbg());
    end else $display("cfg%0d clear_dbg ok", cfg);
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_ready() !== 1'b0 || obs_rd(0) !== 64'h0 || obs_dbg() !== 64'h0) begin
      errors++;
      $display("FAIL cfg%0d mid_clear_reset: ready=%b rd0=%h dbg=%h, need 0/0/0", cfg, obs_ready(), obs_rd(0), obs_dbg());
    end else $display("cfg%0d mid_clear_reset ok", cfg);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    while (obs_ready() !== 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != nregs() - 1) begin
      errors++;
      $display("FAIL cfg%0d mid_clear_rerun_len: %0d cycles, need %0d", cfg, cnt, nregs() - 1);
    end else $display("cfg%0d mid_clear_rerun_len ok", cfg);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int c = 0; c < 2; c++) begin
      cfg = c;
      test_reset();
      test_write_read();
      test_bypass();
      test_back_to_back();
      test_x0();
      test_dbg();
      test_async_reset();
      test_clear();
      test_reset_mid_clear();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
